// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered eight-op bitwise unit with
// optional accumulator feedback and a 2-entry output queue.
module logic_unit_pipe #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [2:0]       op,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             o_zero,
   output logic             o_par,
   output logic [WIDTH-1:0] acc
);

   logic [1:0]       count;
   logic [WIDTH-1:0] q0;
   logic [WIDTH-1:0] q1;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] res;
   logic             push;
   logic             pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // q0 may hold stale data once drained, so gate on out_valid
   assign o      = out_valid ? q0 : '0;
   assign o_zero = (o == '0);
   assign o_par  = ^o;
   assign acc    = acc_q;

   // operand A select and bitwise op decode
   always_comb begin
      op_a = i0;
      if (acc_en)
         op_a = acc_clr ? '0 : acc_q;
      res = '0;
      unique case (op)
         3'b000: res = ~op_a;
         3'b001: res = op_a & i1;
         3'b010: res = op_a | i1;
         3'b011: res = op_a ^ i1;
         3'b100: res = ~(op_a & i1);
         3'b101: res = ~(op_a | i1);
         3'b110: res = ~(op_a ^ i1);
         3'b111: res = op_a;
      endcase
   end

   // two-entry FIFO; q0 is always the head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         q0    <= '0;
         q1    <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0)
                  q0 <= res;
               else
                  q1 <= res;
               count <= count + 2'd1;
            end
            2'b01: begin
               q0    <= q1;
               count <= count - 2'd1;
            end
            // push+pop only possible at count=1
            2'b11: q0 <= res;
            default: ;
         endcase
      end
   end

   // accumulator follows every accepted result, else clears on request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_q <= '0;
      else if (push)
         acc_q <= res;
      else if (acc_clr)
         acc_q <= '0;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the single-bit NOT/AND/OR/XOR gate primitives.
- Applies one of eight bitwise operations to two WIDTH-bit operands selected per transaction.
- Optional accumulate mode: the last result is fed back as operand A.
- Results are buffered in a 2-entry output queue with valid/ready handshakes on both sides, so the block can sit between stimulus generators and checkers in datapath labs.

Parameters:
- WIDTH, 4, operand and result width in bits (valid range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op presented this cycle.
- in_ready  output  1  block can accept a transaction this cycle.
- i0  input  WIDTH  operand A (ignored when acc_en=1).
- i1  input  WIDTH  operand B.
- op  input  3  operation select.
- acc_en  input  1  use accumulator as operand A.
- acc_clr  input  1  clear accumulator.
- out_valid  output  1  queue head holds a result.
- out_ready  input  1  consumer accepts head this cycle.
- o  output  WIDTH  result at queue head.
- o_zero  output  1  head result is all zeros.
- o_par  output  1  XOR-reduction of head result.
- acc  output  WIDTH  current accumulator value.

Behaviour:
- Reset: asynchronous on rst_n=0. Queue count=0, both entries=0, accumulator=0. Outputs: out_valid=0, o=0, o_zero=1, o_par=0, acc=0, in_ready=1. A reset mid-operation discards all queued results.
- Accept: an input transfer occurs when in_valid & in_ready at a rising edge. Output pop occurs when out_valid & out_ready.
- Operand A is selected as follows:
  - acc_en=1: A = accumulator.
  - acc_en=1 and acc_clr=1 in the same accepted cycle: A = 0.
  - acc_en=0: A = i0.
- Operand B is always i1.
- Op encoding (bitwise, result WIDTH bits, no carries):
  - 000 ~A
  - 001 A&B
  - 010 A|B
  - 011 A^B
  - 100 ~(A&B)
  - 101 ~(A|B)
  - 110 ~(A^B)
  - 111 A (pass)
- Accumulator update:
  - Every accepted transaction loads the accumulator with its result, regardless of acc_en.
  - acc_clr=1 with no accept: accumulator <= 0 at the edge.
  - acc_clr=1 with accept: the accumulator loads the result, which was computed with the A rule above.
- Latency: one cycle. A result accepted at edge N is visible at the head (out_valid=1) after edge N if the queue was empty; otherwise it queues behind older results, in order.
- Queue: 2 entries, FIFO order.
  - in_ready = (count < 2). It is registered-state-derived only, with no combinational dependence on out_ready.
  - Push and pop in the same edge: count unchanged, order preserved.
  - count=2: in_ready=0; inputs are ignored even when in_valid=1.
  - count=0: out_valid=0, o/o_zero/o_par show the reset-style values (0/1/0). A pop attempt is ignored.
- Flags: o_zero and o_par are computed from the head entry. They are valid only when out_valid=1, and follow the empty values otherwise.
- op values are all defined. The block has no X-propagation paths from op.

Test Plan:
1. WIDTH=4, out_ready=1, with i0=0101 and i1=0011, sweep op 000..111, one per cycle.
   - Required o, one cycle after each accept: 1010, 0001, 0111, 0110, 1110, 1000, 1001, 0101.
   - o_par at each head: 0, 1, 1, 0, 1, 1, 0, 0.
2. Back-pressure: out_ready=0, push three transactions: op=001 with (1111, 1100), op=010 with (0001, 0010), then a third.
   - After two accepts, in_ready=0 and the third is not taken.
   - Raise out_ready: pops 1100 then 0011. in_ready returns to 1 after the first pop.
3. Accumulate: acc_clr=1 and acc_en=1 with op=010, i1=0001.
   - Result 0001, acc=0001.
   - Next, acc_en=1, op=011, i1=0011: result 0010, acc=0010.
4. Simultaneous push/pop at count=1 with continuous in_valid/out_ready.
   - count stays 1.
   - Results emerge in order, one per cycle, with no bubbles or duplicates.
5. Reset mid-operation: with the queue full and acc=1010, pulse rst_n low between edges.
   - Immediately: out_valid=0, o=0, o_zero=1, acc=0, in_ready=1.
   - No stale result appears after release.
6. Zero flag: op=001 with i0=1010, i1=0101.
   - o=0000, o_zero=1, o_par=0.
